// File: rtl/fpu_addsub_seq_pkg.sv
// fpu_addsub_seq_pkg: shared FPU add/sub sequencing types, e_data mux codes and width defaults
package fpu_addsub_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLASS, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
  localparam logic [1:0] EDATA_NORMAL = 2'b01;
  localparam logic [1:0] EDATA_MIXED = 2'b10;
  localparam int MAN_W_DEF = 27;
  localparam int EXP_W_DEF = 8;
endpackage

// File: rtl/fpu_shift_cnt.sv
// fpu_shift_cnt: loadable saturating up/down shift counter (clk, rst_n, load/load_val, up, dn -> cnt)
module fpu_shift_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         up,
  input  logic         dn,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (up && !(&cnt)) cnt <= cnt + 1'b1;
    else if (dn && |cnt) cnt <= cnt - 1'b1;
endmodule

// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: FPU add/sub sequencer; in_valid/in_ready accept, e_data mux select, stage enables, out_valid/out_ready result
module fpu_addsub_seq
  import fpu_addsub_seq_pkg::*;
#(
  parameter int MAN_W = MAN_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [EXP_W-1:0] exp_diff,
  input  logic             lead_one,
  output logic [1:0]       e_data,
  output logic             ld_en,
  output logic             align_en,
  output logic             add_en,
  output logic             sub_en,
  output logic             norm_en,
  output logic             rnd_en,
  output logic             special,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = $clog2(MAN_W + 1);
  state_t state, nxt;
  logic a_zero, b_zero, any_inf, norm_done;
  logic [CW-1:0] align_ld, align_cnt, norm_cnt;
  assign align_ld = (32'(exp_diff) > MAN_W) ? CW'(MAN_W) : CW'(exp_diff);
  assign norm_done = lead_one || norm_cnt == CW'(MAN_W - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = in_valid ? S_CLASS : S_IDLE;
      S_CLASS: nxt = any_inf ? S_DONE : (align_ld != '0) ? S_ALIGN : S_ADD;
      S_ALIGN: nxt = (align_cnt <= CW'(1)) ? S_ADD : S_ALIGN;
      S_ADD:   nxt = S_NORM;
      S_NORM:  nxt = norm_done ? S_ROUND : S_NORM;
      S_ROUND: nxt = S_DONE;
      S_DONE:  nxt = out_ready ? S_IDLE : S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == S_IDLE;
    ld_en = state == S_IDLE && in_valid;
    align_en = state == S_ALIGN;
    add_en = state == S_ADD;
    norm_en = state == S_NORM && !norm_done;
    rnd_en = state == S_ROUND;
    out_valid = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {a_zero, b_zero, any_inf, sub_en, special} <= '0;
      e_data <= EDATA_NORMAL;
    end else begin
      if (ld_en) {a_zero, b_zero, any_inf, sub_en} <= {exp_a == '0, exp_b == '0, &exp_a | &exp_b, op_sub};
      if (state == S_CLASS && !any_inf) e_data <= (a_zero || b_zero) ? EDATA_MIXED : EDATA_NORMAL;
      special <= (state == S_CLASS && any_inf) ? 1'b1 : (out_valid && out_ready) ? 1'b0 : special;
    end
  fpu_shift_cnt #(.W(CW)) u_align_cnt (
    .clk(clk), .rst_n(rst_n), .load(state == S_CLASS), .load_val(align_ld),
    .up(1'b0), .dn(align_en), .cnt(align_cnt)
  );
  fpu_shift_cnt #(.W(CW)) u_norm_cnt (
    .clk(clk), .rst_n(rst_n), .load(add_en), .load_val('0),
    .up(norm_en), .dn(1'b0), .cnt(norm_cnt)
  );
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb_fpu_addsub_seq: directed self-checking bench for the FPU add/sub sequencer
module tb_fpu_addsub_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, op_sub = 1'b0, lead_one = 1'b0, out_ready = 1'b0;
  logic [7:0] exp_a = '0, exp_b = '0, exp_diff = '0;
  logic in_ready, ld_en, align_en, add_en, sub_en, norm_en, rnd_en, special, out_valid;
  logic [1:0] e_data;
  int checks = 0, errors = 0;
  int n_ld = 0, n_al = 0, n_add = 0, n_nm = 0, n_rnd = 0, n_sub = 0, n_ovl = 0;
  always #5 clk = ~clk;
  fpu_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .exp_a(exp_a), .exp_b(exp_b), .exp_diff(exp_diff), .lead_one(lead_one), .e_data(e_data),
    .ld_en(ld_en), .align_en(align_en), .add_en(add_en), .sub_en(sub_en), .norm_en(norm_en),
    .rnd_en(rnd_en), .special(special), .out_valid(out_valid), .out_ready(out_ready)
  );
  always @(posedge clk) begin
    n_ld += int'(ld_en);
    n_al += int'(align_en);
    n_add += int'(add_en);
    n_nm += int'(norm_en);
    n_rnd += int'(rnd_en);
    n_sub += int'(add_en & sub_en);
    n_ovl += int'($countones({ld_en, align_en, add_en, norm_en, rnd_en}) > 1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string t, input logic [7:0] ea, eb, ed, input logic sub, ld1,
                        input int hold, e_cyc, e_al, e_nm, input logic e_sp, input logic [1:0] e_ed);
    int s_ld, s_al, s_add, s_nm, s_rnd, s_sub, s_ovl;
    int cyc = 0, bad = 0;
    {s_ld, s_al, s_add, s_nm, s_rnd, s_sub, s_ovl} = {n_ld, n_al, n_add, n_nm, n_rnd, n_sub, n_ovl};
    @(negedge clk);
    {exp_a, exp_b, exp_diff, op_sub, lead_one, in_valid} = {ea, eb, ed, sub, ld1, 1'b1};
    #1 chk({t, "_in_ready"}, in_ready, 1);
    chk({t, "_ld_en"}, ld_en, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
      if (e_data !== e_ed) bad++;
    end
    chk({t, "_latency"}, cyc, e_cyc);
    chk({t, "_special"}, special, e_sp);
    chk({t, "_e_data_held"}, bad, 0);
    repeat (hold) begin
      @(posedge clk);
      #1 chk({t, "_hold_valid"}, out_valid, 1);
      chk({t, "_hold_in_ready"}, in_ready, 0);
      chk({t, "_hold_special"}, special, e_sp);
      chk({t, "_hold_e_data"}, e_data, e_ed);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({t, "_idle_in_ready"}, in_ready, 1);
    chk({t, "_idle_out_valid"}, out_valid, 0);
    chk({t, "_idle_special"}, special, 0);
    chk({t, "_n_ld"}, n_ld - s_ld, 1);
    chk({t, "_n_align"}, n_al - s_al, e_al);
    chk({t, "_n_add"}, n_add - s_add, e_sp ? 0 : 1);
    chk({t, "_n_norm"}, n_nm - s_nm, e_nm);
    chk({t, "_n_rnd"}, n_rnd - s_rnd, e_sp ? 0 : 1);
    chk({t, "_n_sub_at_add"}, n_sub - s_sub, (sub && !e_sp) ? 1 : 0);
    chk({t, "_overlap"}, n_ovl - s_ovl, 0);
  endtask
  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_e_data", e_data, 2'b01);
    chk("rst_outs", {ld_en, align_en, add_en, sub_en, norm_en, rnd_en, special, out_valid}, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op("normal", 8'h80, 8'h7F, 8'h01, 1'b0, 1'b1, 0, 5, 1, 0, 1'b0, 2'b01);
    run_op("mixed", 8'h00, 8'h05, 8'h05, 1'b1, 1'b1, 0, 9, 5, 0, 1'b0, 2'b10);
    run_op("special", 8'hFF, 8'h10, 8'hEF, 1'b0, 1'b1, 0, 1, 0, 0, 1'b1, 2'b10);
    run_op("sat", 8'hC0, 8'h80, 8'h40, 1'b0, 1'b0, 0, 57, 27, 26, 1'b0, 2'b01);
    run_op("hold", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 5, 4, 0, 0, 1'b0, 2'b10);
    @(negedge clk);
    {exp_a, exp_b, exp_diff, op_sub, lead_one, in_valid} = {8'h90, 8'h80, 8'h10, 1'b1, 1'b1, 1'b1};
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 chk("abort_in_align", align_en, 1);
    @(negedge clk) rst_n = 1'b0;
    #1 chk("abort_in_ready", in_ready, 1);
    chk("abort_e_data", e_data, 2'b01);
    chk("abort_outs", {ld_en, align_en, add_en, sub_en, norm_en, rnd_en, special, out_valid}, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op("post_rst", 8'h80, 8'h7F, 8'h01, 1'b0, 1'b1, 0, 5, 1, 0, 1'b0, 2'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_addsub_seq.md
# fpu_addsub_seq

Sequencing controller for the FPU adder-subtractor datapath. It accepts one add/sub operation at a time over a valid/ready handshake and classifies the operands. It drives the 2-bit normal/mixed select (`E_Data`) into the operand mux and steps the datapath through align, add, normalize and round with per-stage enables. Iterative align and normalize are counted here, so the datapath stays purely combinational plus stage registers.

## Interface
Parameters:
- `MAN_W`, default 27: significand width incl. hidden, guard and round bits. Caps the align and normalize shift counts.
- `EXP_W`, default 8: exponent width.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: operation request.
- `in_ready`, out, 1: controller can accept a request.
- `op_sub`, in, 1: 1 = subtract, captured on accept.
- `exp_a`, `exp_b`, in, EXP_W: raw operand exponents, sampled on accept.
- `exp_diff`, in, EXP_W: |exp_a − exp_b| from the datapath, sampled in CLASS.
- `lead_one`, in, 1: datapath sum has its MSB set (normalized).
- `e_data`, out, 2: operand-mux select. 01 = normal, 10 = mixed.
- `ld_en`, out, 1: load operand registers.
- `align_en`, out, 1: shift the smaller operand right by one.
- `add_en`, out, 1: capture the sum or difference.
- `sub_en`, out, 1: registered `op_sub`, valid whenever `add_en` is high.
- `norm_en`, out, 1: shift the sum left by one and decrement the exponent.
- `rnd_en`, out, 1: perform rounding.
- `special`, out, 1: result comes from the special-value bypass (Inf/NaN).
- `out_valid`, in/out: out, 1: result is valid.
- `out_ready`, in, 1: consumer accepts the result.

## Operation
- States:
  - IDLE → CLASS → ALIGN → ADD → NORM → ROUND → DONE → IDLE.
  - Special bypass: CLASS → DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`: pulse `ld_en`, register `op_sub` and the exponent-zero flags, go to CLASS.
- CLASS (1 cycle):
  - Either exponent all-ones: set `special` = 1, go to DONE. `e_data` keeps its previous value.
  - Otherwise:
    - `e_data` = 01 if both exponents are non-zero, else 10. This covers one or both operands subnormal.
    - Load `align_cnt` = min(`exp_diff`, MAN_W).
    - Next state is ALIGN if `align_cnt` ≠ 0, else ADD.
- ALIGN:
  - `align_en` = 1 each cycle; decrement `align_cnt`.
  - Leave for ADD in the cycle the count reaches 1.
- ADD (1 cycle): `add_en` = 1. Clear `norm_cnt`; go to NORM.
- NORM, per cycle:
  - If `lead_one` = 1 or `norm_cnt` = MAN_W−1: go to ROUND without asserting `norm_en`.
  - Else: `norm_en` = 1 and `norm_cnt`++.
  - A zero sum therefore terminates after MAN_W−1 shifts.
- ROUND (1 cycle): `rnd_en` = 1, go to DONE.
- DONE:
  - `out_valid` = 1; hold until `out_ready`.
  - On handshake: clear `special`, go to IDLE.
- `in_ready` is 0 in every state except IDLE. There is no accept in the same cycle as a DONE handshake.
- `e_data` is registered and only ever 01 or 10. It never drives 00, so the operand mux never takes its hold path. It is stable from CLASS exit until the next CLASS.
- Every enable output is a single-cycle, registered-state decode. No two of `ld_en`, `align_en`, `add_en`, `norm_en` and `rnd_en` are ever high together.

## Timing
- Reset (async assert, sync release):
  - State goes to IDLE.
  - `e_data` = 01.
  - All enables, `special`, `out_valid` and both counters = 0.
  - `in_ready` = 1.
- Reset asserted mid-operation aborts immediately. The in-flight result is discarded and `out_valid` drops the same cycle.
- Latency from accept edge to `out_valid` high = 1 (CLASS) + A + 1 (ADD) + N + 1 (NORM exit) + 1 (ROUND), where:
  - A = min(`exp_diff`, MAN_W)
  - N = normalize shifts
- Minimum latency = 4 cycles (A = 0, N = 0). Special latency = 1 cycle.
- `out_valid` held with `out_ready` low: state, `special` and `e_data` remain frozen.
- `lead_one` is sampled only in NORM, `exp_diff` only in CLASS. Other values are don't-care.

## Structure
- The shared FPU package holds:
  - the state enum;
  - `EDATA_NORMAL` = 2'b01 and `EDATA_MIXED` = 2'b10, also used by the operand mux instance;
  - the MAN_W and EXP_W defaults.
- One natural sub-module, `fpu_shift_cnt`: a loadable, saturating up/down counter. It is instantiated twice, for `align_cnt` and `norm_cnt`.

## Test plan
- `exp_a` = 0x80, `exp_b` = 0x7F, `exp_diff` = 1, `lead_one` high in NORM → `e_data` = 01, one `align_en`, `out_valid` 5 cycles after accept.
- `exp_a` = 0x00, `exp_b` = 0x05 → `e_data` = 10 by CLASS exit, and it holds through ROUND.
- `exp_a` = 0xFF → `special` = 1, no stage enables, `out_valid` 1 cycle after accept.
- `exp_diff` = 0x40 → exactly 27 `align_en` cycles. `lead_one` low throughout → exactly 26 `norm_en` cycles, then `rnd_en`.
- `out_ready` low for 5 cycles in DONE:
  - outputs stay frozen and `in_ready` stays 0;
  - on `out_ready`, IDLE is reached the next cycle.
- `rst_n` dropped during ALIGN → all outputs at reset values within the same cycle; a fresh request is accepted right after release.
